// File: rtl/pipeline_pkg.sv
// Shared pipeline types: M-stage and MEM/WB bundles plus the memory-access state encoding.
package pipeline_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic {
        IDLE,
        WAIT
    } mem_state_t;

    typedef struct packed {
        logic                  valid;
        logic                  reg_write;
        logic                  result_src;
        logic                  mem_write;
        logic [XLEN-1:0]       alu_result;
        logic [XLEN-1:0]       write_data;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       pc_plus4;
    } m_bundle_t;

    typedef struct packed {
        logic                  valid;
        logic                  reg_write;
        logic                  result_src;
        logic [XLEN-1:0]       alu_result;
        logic [XLEN-1:0]       read_data;
        logic [XLEN-1:0]       pc_plus4;
        logic [REG_ADDR_W-1:0] rd;
    } w_bundle_t;

    // Project an M bundle onto the W fields; a write only counts for a valid slot.
    function automatic w_bundle_t m_to_w(input m_bundle_t m, input logic [XLEN-1:0] rdata);
        w_bundle_t w;
        w.valid      = m.valid;
        w.reg_write  = m.reg_write & m.valid;
        w.result_src = m.result_src;
        w.alu_result = m.alu_result;
        w.read_data  = rdata;
        w.pc_plus4   = m.pc_plus4;
        w.rd         = m.rd;
        return w;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory req/ack bus between the MEM stage (master) and the memory (slave).
interface mem_stage_if #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32
);
    logic                     mem_req;
    logic                     mem_we;
    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]    mem_wdata;
    logic                     mem_ack;
    logic [DATA_WIDTH-1:0]    mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_stage_wb_reg.sv
// Plain MEM/WB pipeline register: load enable, bubble insert, separate read-data enable.
module mem_wb_reg
    import pipeline_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      load,
    input  logic      bubble,
    input  logic      load_rdata,
    input  w_bundle_t d,
    output w_bundle_t q
);

    // A bubble clears only the qualifiers; payload fields keep their last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (bubble) begin
            q.valid     <= 1'b0;
            q.reg_write <= 1'b0;
        end else if (load) begin
            q.valid      <= d.valid;
            q.reg_write  <= d.reg_write;
            q.result_src <= d.result_src;
            q.alu_result <= d.alu_result;
            q.pc_plus4   <= d.pc_plus4;
            q.rd         <= d.rd;
            if (load_rdata) begin
                q.read_data <= d.read_data;
            end
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: issues the data-memory access, stalls upstream while it is outstanding,
// and feeds the MEM/WB register.
module mem_stage
    import pipeline_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  ValidM,
    input  logic                  FlushM,
    input  logic                  RegWriteM,
    input  logic                  ResultSrcM,
    input  logic                  MemWriteM,
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    input  logic [4:0]            RdM,
    input  logic [DATA_WIDTH-1:0] PCPlus4M,

    output logic                  StallM,
    mem_stage_if.master           mem,

    output logic                  ValidW,
    output logic                  RegWriteW,
    output logic                  ResultSrcW,
    output logic [DATA_WIDTH-1:0] ALUResultW,
    output logic [DATA_WIDTH-1:0] ReadDataW,
    output logic [DATA_WIDTH-1:0] PCPlus4W,
    output logic [4:0]            RdW
);

    mem_state_t               state, state_nxt;
    logic                     kill, kill_nxt;
    logic [ADDRESS_WIDTH-1:0] lat_addr, lat_addr_nxt;
    logic                     lat_we, lat_we_nxt;
    logic [DATA_WIDTH-1:0]    lat_wdata, lat_wdata_nxt;

    m_bundle_t                m_c;
    logic                     memop_c;
    logic                     req_c;
    logic                     we_c;
    logic [ADDRESS_WIDTH-1:0] addr_c;
    logic [DATA_WIDTH-1:0]    wdata_c;
    logic                     stall_c;
    logic                     w_load_c;
    logic                     w_bubble_c;
    logic                     w_rdata_en_c;
    w_bundle_t                w_d_c;
    w_bundle_t                w_q;

    always_comb begin
        m_c.valid      = ValidM;
        m_c.reg_write  = RegWriteM;
        m_c.result_src = ResultSrcM;
        m_c.mem_write  = MemWriteM;
        m_c.alu_result = XLEN'(ALUResultM);
        m_c.write_data = XLEN'(WriteDataM);
        m_c.rd         = REG_ADDR_W'(RdM);
        m_c.pc_plus4   = XLEN'(PCPlus4M);
    end

    // A flushed slot never reaches the bus.
    assign memop_c = m_c.valid & ~FlushM & (m_c.result_src | m_c.mem_write);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            kill      <= 1'b0;
            lat_addr  <= '0;
            lat_we    <= 1'b0;
            lat_wdata <= '0;
        end else begin
            state     <= state_nxt;
            kill      <= kill_nxt;
            lat_addr  <= lat_addr_nxt;
            lat_we    <= lat_we_nxt;
            lat_wdata <= lat_wdata_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        kill_nxt      = kill;
        lat_addr_nxt  = lat_addr;
        lat_we_nxt    = lat_we;
        lat_wdata_nxt = lat_wdata;
        req_c         = 1'b0;
        we_c          = lat_we;
        addr_c        = lat_addr;
        wdata_c       = lat_wdata;
        stall_c       = 1'b0;
        w_load_c      = 1'b0;
        w_bubble_c    = 1'b0;
        w_rdata_en_c  = 1'b0;
        w_d_c         = m_to_w(m_c, XLEN'(mem.mem_rdata));

        unique case (state)
            IDLE: begin
                if (memop_c) begin
                    req_c   = 1'b1;
                    addr_c  = ADDRESS_WIDTH'(ALUResultM);
                    we_c    = MemWriteM;
                    wdata_c = WriteDataM;
                    if (mem.mem_ack) begin
                        w_load_c     = 1'b1;
                        w_rdata_en_c = 1'b1;
                    end else begin
                        stall_c       = 1'b1;
                        w_bubble_c    = 1'b1;
                        lat_addr_nxt  = addr_c;
                        lat_we_nxt    = we_c;
                        lat_wdata_nxt = wdata_c;
                        state_nxt     = WAIT;
                    end
                end else if (!ValidM || FlushM) begin
                    w_bubble_c = 1'b1;
                end else begin
                    w_load_c = 1'b1;
                end
            end
            WAIT: begin
                // The bus transaction cannot be aborted; a flush only suppresses writeback.
                req_c = 1'b1;
                if (FlushM) begin
                    kill_nxt = 1'b1;
                end
                if (mem.mem_ack) begin
                    w_load_c        = 1'b1;
                    w_rdata_en_c    = 1'b1;
                    w_d_c.valid     = ValidM & ~kill & ~FlushM;
                    w_d_c.reg_write = RegWriteM & ValidM & ~kill & ~FlushM;
                    kill_nxt        = 1'b0;
                    state_nxt       = IDLE;
                end else begin
                    stall_c    = 1'b1;
                    w_bubble_c = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Reset must drop the request and the stall immediately, even mid-access.
    assign mem.mem_req   = rst_n & req_c;
    assign mem.mem_we    = we_c;
    assign mem.mem_addr  = addr_c;
    assign mem.mem_wdata = wdata_c;
    assign StallM        = rst_n & stall_c;

    mem_wb_reg u_mem_wb_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (w_load_c),
        .bubble     (w_bubble_c),
        .load_rdata (w_rdata_en_c),
        .d          (w_d_c),
        .q          (w_q)
    );

    assign ValidW     = w_q.valid;
    assign RegWriteW  = w_q.reg_write;
    assign ResultSrcW = w_q.result_src;
    assign ALUResultW = DATA_WIDTH'(w_q.alu_result);
    assign ReadDataW  = DATA_WIDTH'(w_q.read_data);
    assign PCPlus4W   = DATA_WIDTH'(w_q.pc_plus4);
    assign RdW        = 5'(w_q.rd);

endmodule
